// File: rtl/clock_set_controller_pkg.sv
// clock_set_controller_pkg: edit-state encodings, time field widths and limits,
// and the wrap-around increment shared by the hour and minute editors.
package clock_set_controller_pkg;
   localparam int HR_W  = 5;
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;
   localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_COMMIT  = 2'd3
   } state_e;
   function automatic logic [MIN_W-1:0] wrap_inc(input logic [MIN_W-1:0] v, input logic [MIN_W-1:0] max_v);
      return (v == max_v) ? '0 : v + 1'b1;
   endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces one raw button, emits a one-cycle
// press pulse on each debounced rising edge, plus optional hold-to-repeat pulses.
module button_conditioner #(
   parameter int DEBOUNCE     = 1000000,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000,
   parameter bit REPEAT_EN    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
   logic [1:0]    sync_q;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          level_q, level_d, level_dly_q;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_tgt;
   logic          fast_q, fast_d;
   logic          mismatch, db_hit, rise, rep_hit;
   always_comb begin
      mismatch  = sync_q[1] ^ level_q;
      db_hit    = mismatch && (db_cnt_q == DW'(DEBOUNCE));
      db_cnt_d  = (!mismatch || db_hit) ? '0 : db_cnt_q + 1'b1;
      level_d   = db_hit ? sync_q[1] : level_q;
      rise      = level_q & ~level_dly_q;
      // first repeat waits the long delay, later ones use the short rate
      rep_tgt   = fast_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
      rep_hit   = REPEAT_EN && level_q && (rep_cnt_q == rep_tgt);
      rep_cnt_d = (REPEAT_EN && level_q) ? (rep_hit ? RW'(1) : rep_cnt_q + 1'b1) : '0;
      fast_d    = REPEAT_EN && level_q && (fast_q || rep_hit);
      press_o   = rise | rep_hit;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         db_cnt_q    <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         rep_cnt_q   <= '0;
         fast_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], btn_i};
         db_cnt_q    <= db_cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         rep_cnt_q   <= rep_cnt_d;
         fast_q      <= fast_d;
      end
   end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: button-driven time-set sequencer that freezes digital_clock,
// edits hours then minutes, and commits the result with a one-cycle load strobe.
module clock_set_controller
   import clock_set_controller_pkg::*;
#(
   parameter int          DEBOUNCE     = 1000000,
   parameter int          REPEAT_DELAY = 50000000,
   parameter int          REPEAT_RATE  = 10000000,
   parameter logic [31:0] TIMEOUT      = 32'd1000000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic [HR_W-1:0]  cur_hr,
   input  logic [MIN_W-1:0] cur_min,
   output logic             clk_run,
   output logic             load,
   output logic [HR_W-1:0]  load_hr,
   output logic [MIN_W-1:0] load_min,
   output logic [SEC_W-1:0] load_sec,
   output logic [1:0]       edit_mode,
   output logic [HR_W-1:0]  edit_hr,
   output logic [MIN_W-1:0] edit_min
);
   state_e           state_q, state_d;
   logic [HR_W-1:0]  edit_hr_q, edit_hr_d, load_hr_q, load_hr_d;
   logic [MIN_W-1:0] edit_min_q, edit_min_d, load_min_q, load_min_d;
   logic             load_q, load_d;
   logic [31:0]      idle_q, idle_d;
   logic             mode_p, inc_p, in_edit, timed_out;
   button_conditioner #(
      .DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)
   ) u_mode (
      .clk(clk), .reset(reset), .btn_i(btn_mode), .press_o(mode_p)
   );
   button_conditioner #(
      .DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
   ) u_inc (
      .clk(clk), .reset(reset), .btn_i(btn_inc), .press_o(inc_p)
   );
   always_comb begin
      state_d    = state_q;
      edit_hr_d  = edit_hr_q;
      edit_min_d = edit_min_q;
      in_edit    = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
      timed_out  = in_edit && (idle_q == TIMEOUT);
      // a mode press always takes precedence over a coincident inc press
      if (timed_out) begin
         state_d = ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: if (mode_p) begin
               state_d    = ST_SET_HR;
               edit_hr_d  = cur_hr;
               edit_min_d = cur_min;
            end
            ST_SET_HR: begin
               if (mode_p) state_d = ST_SET_MIN;
               else if (inc_p) edit_hr_d = HR_W'(wrap_inc(MIN_W'(edit_hr_q), MIN_W'(HR_MAX)));
            end
            ST_SET_MIN: begin
               if (mode_p) state_d = ST_COMMIT;
               else if (inc_p) edit_min_d = wrap_inc(edit_min_q, MIN_MAX);
            end
            default: state_d = ST_RUN;
         endcase
      end
      idle_d     = (mode_p || inc_p || !in_edit) ? '0 : idle_q + 32'd1;
      load_d     = (state_d == ST_COMMIT);
      load_hr_d  = load_d ? edit_hr_q : load_hr_q;
      load_min_d = load_d ? edit_min_q : load_min_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         edit_hr_q  <= '0;
         edit_min_q <= '0;
         load_q     <= 1'b0;
         load_hr_q  <= '0;
         load_min_q <= '0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         edit_hr_q  <= edit_hr_d;
         edit_min_q <= edit_min_d;
         load_q     <= load_d;
         load_hr_q  <= load_hr_d;
         load_min_q <= load_min_d;
         idle_q     <= idle_d;
      end
   end
   assign clk_run   = (state_q == ST_RUN);
   assign load      = load_q;
   assign load_hr   = load_hr_q;
   assign load_min  = load_min_q;
   assign load_sec  = '0;
   assign edit_mode = (state_q == ST_COMMIT) ? 2'(ST_SET_MIN) : 2'(state_q);
   assign edit_hr   = edit_hr_q;
   assign edit_min  = edit_min_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: button-hold stimulus predicted by an event-level model;
// expected output snapshots are queued and matched by a change-driven monitor.
module tb_clock_set_controller;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RR = 5;
   localparam int TO = 200;
   logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
   logic [4:0] cur_hr = '0;
   logic [5:0] cur_min = '0;
   logic       clk_run, load;
   logic [4:0] load_hr, edit_hr;
   logic [5:0] load_min, load_sec, edit_min;
   logic [1:0] edit_mode;
   int cyc = 0, checks = 0, passes = 0;
   typedef struct {
      int c;
      logic [1:0] mode;
      logic run, ld;
      logic [4:0] ehr, lhr;
      logic [5:0] emin, lmin, lsec;
   } snap_t;
   snap_t exp_q[$];
   snap_t last_s, prev_s;
   bit mon_en = 1'b0;
   int st, last_clr;
   logic [4:0] m_hr, m_lhr;
   logic [5:0] m_min, m_lmin;
   clock_set_controller #(
      .DEBOUNCE(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(32'(TO))
   ) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hr(cur_hr), .cur_min(cur_min), .clk_run(clk_run), .load(load),
      .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
      .edit_mode(edit_mode), .edit_hr(edit_hr), .edit_min(edit_min)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic bit same(snap_t a, snap_t b);
      return a.mode == b.mode && a.run == b.run && a.ld == b.ld && a.ehr == b.ehr &&
             a.emin == b.emin && a.lhr == b.lhr && a.lmin == b.lmin && a.lsec == b.lsec;
   endfunction
   function automatic string fmt(snap_t s);
      return $sformatf("cyc=%0d mode=%0d run=%0b load=%0b ehr=%0d emin=%0d lhr=%0d lmin=%0d lsec=%0d",
                       s.c, s.mode, s.run, s.ld, s.ehr, s.emin, s.lhr, s.lmin, s.lsec);
   endfunction
   function automatic snap_t sample();
      snap_t s;
      s.c = cyc; s.mode = edit_mode; s.run = clk_run; s.ld = load; s.ehr = edit_hr;
      s.emin = edit_min; s.lhr = load_hr; s.lmin = load_min; s.lsec = load_sec;
      return s;
   endfunction
   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
   endtask
   // queue a snapshot only when the visible outputs actually change
   task automatic emit(int v, logic [1:0] mode, logic run, logic ld);
      snap_t s;
      s.c = v; s.mode = mode; s.run = run; s.ld = ld; s.ehr = m_hr; s.emin = m_min;
      s.lhr = m_lhr; s.lmin = m_lmin; s.lsec = '0;
      if (!same(s, last_s)) exp_q.push_back(s);
      last_s = s;
   endtask
   task automatic timeout_until(int v);
      if (st != 0 && last_clr + TO + 1 <= v) begin
         st = 0;
         emit(last_clr + TO + 1, 2'd0, 1'b1, 1'b0);
      end
   endtask
   // v = cycle in which the effect of a press becomes visible
   task automatic model_event(int v, bit is_mode, logic [4:0] ch, logic [5:0] cm);
      int t;
      t = last_clr + TO + 1;
      if (st != 0 && t <= v) begin
         st = 0;
         emit(t, 2'd0, 1'b1, 1'b0);
         if (t == v) return;
      end
      if (is_mode) begin
         if (st == 0) begin
            m_hr = ch; m_min = cm; st = 1; last_clr = v;
            emit(v, 2'd1, 1'b0, 1'b0);
         end else if (st == 1) begin
            st = 2; last_clr = v;
            emit(v, 2'd2, 1'b0, 1'b0);
         end else begin
            m_lhr = m_hr; m_lmin = m_min;
            emit(v, 2'd2, 1'b0, 1'b1);
            st = 0;
            emit(v + 1, 2'd0, 1'b1, 1'b0);
         end
      end else if (st != 0) begin
         if (st == 1) m_hr = (m_hr == 23) ? 5'd0 : m_hr + 5'd1;
         else m_min = (m_min == 59) ? 6'd0 : m_min + 6'd1;
         last_clr = v;
         emit(v, 2'(st), 1'b0, 1'b0);
      end
   endtask
   task automatic hold(bit m, bit i, int n, logic [4:0] ch, logic [5:0] cm);
      int p, gap, v0;
      p = cyc;
      gap = $urandom_range(8, 14);
      v0 = p + D + 4;
      cur_hr = ch; cur_min = cm; btn_mode = m; btn_inc = i;
      if (m) model_event(v0, 1'b1, ch, cm);
      else begin
         model_event(v0, 1'b0, ch, cm);
         for (int t = RD; t < n; t += RR) model_event(v0 + t, 1'b0, ch, cm);
      end
      timeout_until(p + n + gap);
      repeat (n) @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0;
      repeat (gap) @(negedge clk);
   endtask
   task automatic idle(int n);
      timeout_until(cyc + n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset();
      int p;
      p = cyc;
      reset = 1'b1;
      st = 0; m_hr = '0; m_min = '0; m_lhr = '0; m_lmin = '0;
      emit(p + 1, 2'd0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   always @(negedge clk) begin : monitor
      snap_t s;
      snap_t e;
      if (mon_en) begin
         s = sample();
         if (!same(s, prev_s)) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL unexpected_change got {%s} expected no change", fmt(s));
            else begin
               e = exp_q.pop_front();
               if (same(s, e) && s.c == e.c) passes++;
               else $display("FAIL output_change got {%s} expected {%s}", fmt(s), fmt(e));
            end
            prev_s = s;
         end
      end
   end
   initial begin
      st = 0; last_clr = 0; m_hr = '0; m_min = '0; m_lhr = '0; m_lmin = '0;
      last_s.c = 0; last_s.mode = 2'd0; last_s.run = 1'b1; last_s.ld = 1'b0; last_s.ehr = '0;
      last_s.emin = '0; last_s.lhr = '0; last_s.lmin = '0; last_s.lsec = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_clk_run", int'(clk_run), 1);
      chk("reset_load", int'(load), 0);
      chk("reset_edit_mode", int'(edit_mode), 0);
      chk("reset_load_hr", int'(load_hr), 0);
      chk("reset_load_min", int'(load_min), 0);
      chk("reset_load_sec", int'(load_sec), 0);
      chk("reset_edit_hr", int'(edit_hr), 0);
      chk("reset_edit_min", int'(edit_min), 0);
      prev_s = last_s;
      mon_en = 1'b1;
      idle(20);
      chk("idle_clk_run", int'(clk_run), 1);
      hold(1'b1, 1'b0, 10, 5'd22, 6'd58);
      hold(1'b0, 1'b1, 8, 5'd3, 6'd7);
      hold(1'b0, 1'b1, 8, 5'd3, 6'd7);
      hold(1'b1, 1'b0, 8, 5'd3, 6'd7);
      for (int k = 0; k < 3; k++) hold(1'b0, 1'b1, 8, 5'd3, 6'd7);
      hold(1'b1, 1'b0, 8, 5'd3, 6'd7);
      chk("commit_load_hr", int'(load_hr), 0);
      chk("commit_load_min", int'(load_min), 1);
      hold(1'b1, 1'b0, 8, 5'd5, 6'd30);
      hold(1'b0, 1'b1, 40, 5'd5, 6'd30);
      chk("repeat_edit_hr", int'(edit_hr), 10);
      hold(1'b1, 1'b0, 8, 5'd5, 6'd30);
      idle(250);
      chk("timeout_clk_run", int'(clk_run), 1);
      hold(1'b1, 1'b0, 8, 5'd17, 6'd41);
      do_reset();
      hold(1'b1, 1'b1, 9, 5'd12, 6'd34);
      for (int k = 0; k < 40; k++) begin
         int r;
         logic [4:0] ch;
         logic [5:0] cm;
         r = $urandom_range(0, 9);
         ch = 5'($urandom_range(0, 23));
         cm = 6'($urandom_range(0, 59));
         if (r <= 2) hold(1'b1, 1'b0, $urandom_range(6, 12), ch, cm);
         else if (r <= 6) hold(1'b0, 1'b1, $urandom_range(6, 50), ch, cm);
         else if (r == 7) hold(1'b1, 1'b1, $urandom_range(6, 15), ch, cm);
         else if (r == 8) idle($urandom_range(150, 260));
         else do_reset();
      end
      idle(260);
      repeat (5) @(negedge clk);
      chk("pending_expected", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
